// File: rtl/piso_stream_serializer_pkg.sv
// Shared constants for the parallel-in/serial-out stream serializer:
// level names, FSM state encodings and the gap counter width.
package piso_stream_serializer_pkg;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    // FSM state encodings (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Gap counter covers GAP values 0..15
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register for the serializer input: captures a word on push,
// releases it on pop, and is emptied by flush. A push and a pop on the same edge
// leave the register full with the new word.
module piso_hold_reg
    import piso_stream_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // Capture on push, release on pop, flush outranks both
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: registers use <= so every flop samples the pre-edge values of its inputs.
        if (!nrst) begin
            full <= NO;
            // NOTE: the data word is reset as well, so a flushed or reset entry never exposes a stale word.
            data <= '0;
        end else if (flush) begin
            full <= NO;
            data <= '0;
        end else if (push) begin
            full <= YES;
            data <= push_data;
        end else if (pop) begin
            full <= NO;
        end
    end

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer. Words arrive through a valid/ready handshake
// into a one-entry holding register and are shifted out one bit per cycle under a
// frame-enable (link_out). Optional idle gap between frames, synchronous abort.
module piso_stream_serializer
    import piso_stream_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             bit_out,
    output logic             link_out,
    output logic             frame_done,
    output logic             busy
);

    localparam int                   CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    // Unused when GAP is 0: the FSM never enters S_GAP in that case
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [WIDTH-1:0]     shreg;
    logic [WIDTH-1:0]     shreg_next;
    logic [WIDTH-1:0]     hold_data;
    logic                 hold_full;
    logic                 in_shift;
    logic                 last_bit;
    logic                 gap_end;
    logic                 frame_slot;
    logic                 start_frame;

    assign load_ready = !hold_full && !abort;

    assign in_shift   = (state == S_SHIFT);
    assign last_bit   = in_shift && (bit_cnt == LAST_BIT);
    assign gap_end    = (state == S_GAP) && (gap_cnt == GAP_LAST);
    // A new frame may start from idle, at the end of the gap, or straight after
    // the last bit when there is no gap to insert.
    assign frame_slot  = (state == S_IDLE) || gap_end || (last_bit && (GAP == 0));
    assign start_frame = hold_full && !abort && frame_slot;

    // Shift direction is fixed at elaboration
    assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .nrst      (nrst),
        .push      (load_valid && load_ready),
        .push_data (load_data),
        .pop       (start_frame),
        .flush     (abort),
        .data      (hold_data),
        .full      (hold_full)
    );

    // FSM, bit/gap counters and shift register advance once per clock
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else if (abort) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else if (start_frame) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= hold_data;
        end else begin
            case (state)
                S_SHIFT: begin
                    if (last_bit) begin
                        state   <= (GAP != 0) ? S_GAP : S_IDLE;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        shreg   <= shreg_next;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state; data is gated by the frame enable
    assign link_out   = in_shift;
    assign bit_out    = in_shift && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign frame_done = last_bit && !abort;
    assign busy       = (state != S_IDLE) || hold_full;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Testbench for piso_stream_serializer. Three instances (MSB-first no gap,
// LSB-first no gap, MSB-first with a 3-cycle gap) are checked every cycle against
// a word-queue model of the serial link.
module tb_piso_stream_serializer;

    localparam int W     = 8;
    localparam int N_DUT = 3;

    logic             clk;
    logic             nrst;
    logic [W-1:0]     load_data [N_DUT];
    logic [N_DUT-1:0] load_valid;
    logic [N_DUT-1:0] abort;
    logic [N_DUT-1:0] load_ready;
    logic [N_DUT-1:0] bit_out;
    logic [N_DUT-1:0] link_out;
    logic [N_DUT-1:0] frame_done;
    logic [N_DUT-1:0] busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: words accepted but not yet fully sent, per instance
    logic [W-1:0] exp_q [N_DUT][$];
    int bits_seen [N_DUT];
    int gap_left  [N_DUT];
    int low_run   [N_DUT];
    int done_cnt  [N_DUT];
    bit b2b       [N_DUT];
    bit acc_flag  [N_DUT];

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
        .clk(clk), .nrst(nrst), .load_data(load_data[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .abort(abort[0]), .bit_out(bit_out[0]),
        .link_out(link_out[0]), .frame_done(frame_done[0]), .busy(busy[0]));

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
        .clk(clk), .nrst(nrst), .load_data(load_data[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .abort(abort[1]), .bit_out(bit_out[1]),
        .link_out(link_out[1]), .frame_done(frame_done[1]), .busy(busy[1]));

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(3)) u_gap (
        .clk(clk), .nrst(nrst), .load_data(load_data[2]), .load_valid(load_valid[2]),
        .load_ready(load_ready[2]), .abort(abort[2]), .bit_out(bit_out[2]),
        .link_out(link_out[2]), .frame_done(frame_done[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit msb_of(input int d);
        return d != 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 2) ? 3 : 0;
    endfunction

    function automatic string tg(input int d, input string s);
        return $sformatf("dut%0d %s", d, s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holding register is occupied by every queued word that has not started
    function automatic bit model_ready(input int d);
        int pending;
        pending = exp_q[d].size() - ((bits_seen[d] > 0) ? 1 : 0);
        return (pending == 0) && !abort[d];
    endfunction

    task automatic flush_model(input int d);
        exp_q[d].delete();
        bits_seen[d] = 0;
        gap_left[d]  = 0;
        b2b[d]       = 1'b0;
        low_run[d]   = 1000;
    endtask

    // Compare one instance's outputs against the model for the current cycle
    task automatic sample_dut(input int d);
        logic [W-1:0] w;
        int           k;
        logic         exp_bit;
        logic         exp_busy;
        exp_busy = (exp_q[d].size() > 0) || (gap_left[d] > 0);
        check(tg(d, "busy"), {31'd0, busy[d]}, {31'd0, exp_busy});
        if (link_out[d]) begin
            if (exp_q[d].size() == 0) begin
                check(tg(d, "link_out without word"), {31'd0, link_out[d]}, 32'd0);
            end else begin
                if (bits_seen[d] == 0) begin
                    if (b2b[d]) check(tg(d, "gap length"), low_run[d], gap_of(d));
                    else        check(tg(d, "gap minimum"), {31'd0, low_run[d] >= gap_of(d)}, 32'd1);
                end
                w = exp_q[d][0];
                k = bits_seen[d];
                exp_bit = msb_of(d) ? w[W-1-k] : w[k];
                check(tg(d, $sformatf("bit %0d of %02h", k, w)), {31'd0, bit_out[d]}, {31'd0, exp_bit});
                bits_seen[d]++;
                check(tg(d, "frame_done"), {31'd0, frame_done[d]},
                      {31'd0, (bits_seen[d] == W) && !abort[d]});
                if (bits_seen[d] == W) begin
                    void'(exp_q[d].pop_front());
                    bits_seen[d] = 0;
                    done_cnt[d]++;
                    b2b[d]      = exp_q[d].size() > 0;
                    gap_left[d] = gap_of(d);
                    low_run[d]  = 0;
                end
            end
        end else begin
            check(tg(d, "bit_out idle"), {31'd0, bit_out[d]}, 32'd0);
            check(tg(d, "frame_done idle"), {31'd0, frame_done[d]}, 32'd0);
            if (bits_seen[d] != 0) begin
                check(tg(d, "link_out dropped mid-frame"), bits_seen[d], 0);
                void'(exp_q[d].pop_front());
                bits_seen[d] = 0;
            end
            low_run[d]++;
            if (gap_left[d] > 0) gap_left[d]--;
        end
        check(tg(d, "load_ready"), {31'd0, load_ready[d]}, {31'd0, model_ready(d)});
    endtask

    // One clock: record accepted words and aborts, then sample on the falling edge
    task automatic tick();
        for (int d = 0; d < N_DUT; d++) begin
            acc_flag[d] = 1'b0;
            if (load_valid[d] && model_ready(d)) begin
                exp_q[d].push_back(load_data[d]);
                acc_flag[d] = 1'b1;
            end
            if (abort[d]) flush_model(d);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) sample_dut(d);
    endtask

    task automatic push_word(input int d, input logic [W-1:0] w);
        int n;
        n = 0;
        load_data[d]  = w;
        load_valid[d] = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_flag[d] && n < 100);
        check(tg(d, "accept timeout"), {31'd0, n < 100}, 32'd1);
        load_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((exp_q[d].size() > 0 || gap_left[d] > 0) && n < 300) begin
            tick();
            n++;
        end
        check(tg(d, "drain timeout"), {31'd0, n < 300}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int base;
        int n;
        nrst       = 1'b0;
        load_valid = '0;
        abort      = '0;
        for (int d = 0; d < N_DUT; d++) begin
            load_data[d] = '0;
            done_cnt[d]  = 0;
            acc_flag[d]  = 1'b0;
            flush_model(d);
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            check(tg(d, "reset bit_out"), {31'd0, bit_out[d]}, 32'd0);
            check(tg(d, "reset link_out"), {31'd0, link_out[d]}, 32'd0);
            check(tg(d, "reset frame_done"), {31'd0, frame_done[d]}, 32'd0);
            check(tg(d, "reset busy"), {31'd0, busy[d]}, 32'd0);
            check(tg(d, "reset load_ready"), {31'd0, load_ready[d]}, 32'd1);
        end
        #2 nrst = 1'b1;
        @(negedge clk);

        // MSB-first single frame of 0xC4
        base = done_cnt[0];
        push_word(0, 8'hC4);
        drain(0);
        check("dut0 frames for C4", done_cnt[0] - base, 1);

        // LSB-first single frame of 0xC4
        base = done_cnt[1];
        push_word(1, 8'hC4);
        drain(1);
        check("dut1 frames for C4", done_cnt[1] - base, 1);

        // Back-to-back 0xFF, 0x00 with no gap
        base = done_cnt[0];
        push_word(0, 8'hFF);
        push_word(0, 8'h00);
        drain(0);
        check("dut0 back-to-back frames", done_cnt[0] - base, 2);

        // Two queued words with a 3-cycle gap
        base = done_cnt[2];
        push_word(2, 8'h96);
        push_word(2, 8'h3B);
        drain(2);
        check("dut2 gapped frames", done_cnt[2] - base, 2);

        // Abort while bit 4 of 0xA5 is on the line, with a coincident load
        base = done_cnt[0];
        push_word(0, 8'hA5);
        n = 0;
        while (bits_seen[0] != 5 && n < 40) begin
            tick();
            n++;
        end
        check("dut0 abort point reached", {31'd0, n < 40}, 32'd1);
        abort[0]      = 1'b1;
        load_valid[0] = 1'b1;
        load_data[0]  = 8'h5A;
        tick();
        check("dut0 link_out after abort", {31'd0, link_out[0]}, 32'd0);
        abort[0]      = 1'b0;
        load_valid[0] = 1'b0;
        #1 check("dut0 load_ready after abort", {31'd0, load_ready[0]}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        check("dut0 no frame_done for aborted frame", done_cnt[0] - base, 0);

        // Asynchronous reset in the middle of a frame
        push_word(0, 8'h77);
        tick();
        tick();
        tick();
        #3 nrst = 1'b0;
        for (int d = 0; d < N_DUT; d++) flush_model(d);
        #1;
        check("dut0 async reset link_out", {31'd0, link_out[0]}, 32'd0);
        check("dut0 async reset bit_out", {31'd0, bit_out[0]}, 32'd0);
        check("dut0 async reset busy", {31'd0, busy[0]}, 32'd0);
        check("dut0 async reset load_ready", {31'd0, load_ready[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) sample_dut(d);
        #2 nrst = 1'b1;
        base = done_cnt[0];
        push_word(0, 8'h3C);
        drain(0);
        check("dut0 frame after reset", done_cnt[0] - base, 1);

        // Random words with random idle spacing on every instance
        for (int d = 0; d < N_DUT; d++) begin
            base = done_cnt[d];
            for (int i = 0; i < 6; i++) begin
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) tick();
                push_word(d, W'($urandom));
            end
            drain(d);
            check(tg(d, "random frames"), done_cnt[d] - base, 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
